// File: rtl/count.sv
// Up/down binary counter with compare-match and wrap (overflow) pulse.
// Free-running over the full range, or bounded by match_value.
module count #(
    parameter int bin = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    input  logic [1:0]     mode,
    input  logic [bin-1:0] match_value,
    output logic [bin-1:0] oCounter,
    output logic           match,
    output logic           ovf
);

    localparam logic [bin-1:0] CNT_ONE = bin'(1);
    localparam logic [bin-1:0] CNT_MAX = '1;

    logic [bin-1:0] cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           up_n;
    logic           bounded;

    assign up_n    = mode[0];
    assign bounded = mode[1];

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (enable) begin
            unique case ({bounded, up_n})
                2'b00: begin
                    cnt_d = cnt_q + CNT_ONE;
                    ovf_d = (cnt_q == CNT_MAX);
                end
                2'b01: begin
                    cnt_d = cnt_q - CNT_ONE;
                    ovf_d = (cnt_q == '0);
                end
                2'b10: begin
                    // A count above a freshly lowered limit still wraps at full scale.
                    if ((cnt_q == match_value) || (cnt_q == CNT_MAX)) begin
                        cnt_d = '0;
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                2'b11: begin
                    if (cnt_q == '0) begin
                        cnt_d = match_value;
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                    ovf_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign oCounter = cnt_q;
    assign ovf      = ovf_q;
    assign match    = (cnt_q == match_value);

endmodule

// File: tb/tb_count.sv
// Self-checking bench for count: a 32-bit and a 4-bit instance share control stimulus,
// checked against an arithmetic reference model, a vector table and directed sequences.
module tb_count;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic [31:0] mv32, cnt32;
    logic [3:0]  mv4, cnt4;
    logic        match32, ovf32, match4, ovf4;

    int     n_chk = 0;
    int     n_fail = 0;
    longint m32, m4;
    bit     o32, o4;

    typedef struct {
        bit       en;
        bit [1:0] md;
        bit [3:0] mv;
        int       cnt;
        bit       ov;
        bit       mt;
    } vec_t;
    vec_t tbl[18];

    always #5 clk = ~clk;

    count #(.bin(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .match_value(mv32), .oCounter(cnt32), .match(match32), .ovf(ovf32)
    );

    count #(.bin(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .match_value(mv4), .oCounter(cnt4), .match(match4), .ovf(ovf4)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic over modulus M.
    task automatic model_step(input longint c, input bit en, input bit [1:0] md,
                              input longint mv, input longint M,
                              output longint n, output bit o);
        n = c;
        o = 1'b0;
        if (en) begin
            if (!md[1] && !md[0]) begin
                n = (c + 1) % M;
                o = (n == 0);
            end else if (!md[1] && md[0]) begin
                n = (c + M - 1) % M;
                o = (c == 0);
            end else if (md[1] && !md[0]) begin
                if (c == mv) n = 0;
                else         n = (c + 1) % M;
                o = (n == 0);
            end else begin
                if (c == 0) begin
                    n = mv;
                    o = 1'b1;
                end else begin
                    n = c - 1;
                end
            end
        end
    endtask

    task automatic edge_step();
        longint n;
        bit     o;
        model_step(m32, enable, mode, longint'(mv32), 64'd1 << 32, n, o);
        m32 = n; o32 = o;
        model_step(m4, enable, mode, longint'(mv4), 64'd16, n, o);
        m4 = n; o4 = o;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_model(input string nm);
        chk({nm, " cnt32"},   longint'(cnt32), m32);
        chk({nm, " ovf32"},   longint'(ovf32), longint'(o32));
        chk({nm, " match32"}, longint'(match32), longint'(m32 == longint'(mv32)));
        chk({nm, " cnt4"},    longint'(cnt4), m4);
        chk({nm, " ovf4"},    longint'(ovf4), longint'(o4));
        chk({nm, " match4"},  longint'(match4), longint'(m4 == longint'(mv4)));
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        m32 = 0; m4 = 0; o32 = 0; o4 = 0;
        chk("reset cnt32 async", longint'(cnt32), 0);
        chk("reset cnt4 async",  longint'(cnt4), 0);
        chk("reset ovf4 async",  longint'(ovf4), 0);
        @(posedge clk);
        #1;
        chk("reset cnt4 held", longint'(cnt4), 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        mode    = 2'b00;
        mv32    = 32'd7;
        mv4     = 4'd0;
        m32 = 0; m4 = 0; o32 = 0; o4 = 0;

        // {en, mode, mv, expected cnt4, ovf4, match4}, starting from 0 after reset
        tbl[0]  = '{1'b1, 2'b10, 4'd3,  1,  1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'b10, 4'd3,  2,  1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'b10, 4'd3,  3,  1'b0, 1'b1};
        tbl[3]  = '{1'b1, 2'b10, 4'd3,  0,  1'b1, 1'b0};
        tbl[4]  = '{1'b1, 2'b10, 4'd3,  1,  1'b0, 1'b0};
        tbl[5]  = '{1'b0, 2'b10, 4'd3,  1,  1'b0, 1'b0};
        tbl[6]  = '{1'b0, 2'b10, 4'd3,  1,  1'b0, 1'b0};
        tbl[7]  = '{1'b1, 2'b00, 4'd3,  2,  1'b0, 1'b0};
        tbl[8]  = '{1'b1, 2'b11, 4'd2,  1,  1'b0, 1'b0};
        tbl[9]  = '{1'b1, 2'b11, 4'd2,  0,  1'b0, 1'b0};
        tbl[10] = '{1'b1, 2'b11, 4'd2,  2,  1'b1, 1'b1};
        tbl[11] = '{1'b1, 2'b11, 4'd2,  1,  1'b0, 1'b0};
        tbl[12] = '{1'b1, 2'b01, 4'd9,  0,  1'b0, 1'b0};
        tbl[13] = '{1'b1, 2'b01, 4'd9,  15, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 2'b00, 4'd15, 0,  1'b1, 1'b0};
        tbl[15] = '{1'b1, 2'b10, 4'd0,  0,  1'b1, 1'b1};
        tbl[16] = '{1'b1, 2'b11, 4'd0,  0,  1'b1, 1'b1};
        tbl[17] = '{1'b1, 2'b10, 4'd0,  0,  1'b1, 1'b1};

        @(negedge clk);
        #1;
        chk("por cnt32",   longint'(cnt32), 0);
        chk("por ovf32",   longint'(ovf32), 0);
        chk("por match32", longint'(match32), 0);
        chk("por match4",  longint'(match4), 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Vector table on the 4-bit instance
        for (int i = 0; i < 18; i++) begin
            enable = tbl[i].en;
            mode   = tbl[i].md;
            mv4    = tbl[i].mv;
            mv32   = 32'(tbl[i].mv);
            edge_step();
            chk($sformatf("tbl[%0d] cnt4", i),   longint'(cnt4), longint'(tbl[i].cnt));
            chk($sformatf("tbl[%0d] ovf4", i),   longint'(ovf4), longint'(tbl[i].ov));
            chk($sformatf("tbl[%0d] match4", i), longint'(match4), longint'(tbl[i].mt));
            chk_model($sformatf("tbl[%0d]", i));
        end

        // Bounded down, limit 25, 32-bit: period of 26 edges
        do_reset();
        enable = 1'b1; mode = 2'b11; mv32 = 32'd25; mv4 = 4'd9;
        edge_step();
        chk("bdown first cnt32",   longint'(cnt32), 25);
        chk("bdown first ovf32",   longint'(ovf32), 1);
        chk("bdown first match32", longint'(match32), 1);
        for (int i = 24; i >= 0; i--) begin
            edge_step();
            chk($sformatf("bdown cnt32 %0d", i), longint'(cnt32), longint'(i));
            chk($sformatf("bdown ovf32 %0d", i), longint'(ovf32), 0);
        end
        edge_step();
        chk("bdown reload cnt32", longint'(cnt32), 25);
        chk("bdown reload ovf32", longint'(ovf32), 1);

        // Free-run wrap both directions
        do_reset();
        mode = 2'b00;
        for (int i = 1; i <= 15; i++) edge_step();
        chk("free up cnt4 15", longint'(cnt4), 15);
        chk("free up ovf4 15", longint'(ovf4), 0);
        edge_step();
        chk("free up wrap cnt4", longint'(cnt4), 0);
        chk("free up wrap ovf4", longint'(ovf4), 1);
        mode = 2'b01;
        edge_step();
        chk("free down wrap cnt4",  longint'(cnt4), 15);
        chk("free down wrap ovf4",  longint'(ovf4), 1);
        chk_model("free wrap");
        do_reset();
        edge_step();
        chk("free down wrap cnt32", longint'(cnt32), 64'hFFFF_FFFF);
        chk("free down wrap ovf32", longint'(ovf32), 1);

        // Hold with enable low at 7, then resume
        do_reset();
        mode = 2'b00;
        for (int i = 0; i < 7; i++) edge_step();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge_step();
            chk("hold cnt4", longint'(cnt4), 7);
            chk("hold ovf4", longint'(ovf4), 0);
        end
        enable = 1'b1;
        edge_step();
        chk("resume cnt4", longint'(cnt4), 8);

        // Asynchronous reset between edges at count 12
        for (int i = 0; i < 4; i++) edge_step();
        chk("pre-reset cnt4", longint'(cnt4), 12);
        #2;
        do_reset();
        edge_step();
        chk("post-reset cnt4",  longint'(cnt4), 1);
        chk("post-reset cnt32", longint'(cnt32), 1);

        // Limit lowered below the count in bounded up
        do_reset();
        mode = 2'b10; mv4 = 4'd15; mv32 = 32'd100;
        for (int i = 0; i < 10; i++) edge_step();
        mv4 = 4'd5;
        for (int i = 11; i <= 15; i++) begin
            edge_step();
            chk("lowered cnt4", longint'(cnt4), longint'(i));
        end
        edge_step();
        chk("lowered wrap cnt4", longint'(cnt4), 0);
        chk("lowered wrap ovf4", longint'(ovf4), 1);
        for (int i = 1; i <= 5; i++) begin
            edge_step();
            chk("lowered cycle cnt4", longint'(cnt4), longint'(i));
        end
        edge_step();
        chk("lowered rewrap cnt4", longint'(cnt4), 0);
        chk("lowered rewrap ovf4", longint'(ovf4), 1);

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                mv32 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
                mv4  = 4'($urandom);
            end
            edge_step();
            chk_model($sformatf("rand[%0d]", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
